// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one RAM port (data first).
// Latency: IDLE -> DATA/INSTR -> RESP; hit pulses 2 cycles after sampling with an immediate ramready.
module mem_arbiter #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] iload,
  output logic        ihit,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    INSTR = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] iload_q, iload_d;
  logic [31:0] dload_q, dload_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic        is_data_q, is_data_d;

  logic        done;
  logic [31:0] cap_val;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      err_q     <= 1'b0;
      iload_q   <= 32'd0;
      dload_q   <= 32'd0;
      addr_q    <= 32'd0;
      store_q   <= 32'd0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      is_data_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      iload_q   <= iload_d;
      dload_q   <= dload_d;
      addr_q    <= addr_d;
      store_q   <= store_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      is_data_q <= is_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    iload_d   = iload_q;
    dload_d   = dload_q;
    addr_d    = addr_q;
    store_d   = store_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    is_data_d = is_data_q;
    done      = 1'b0;
    cap_val   = 32'd0;

    case (state_q)
      IDLE: begin
        if (dREN || dWEN) begin
          state_d   = DATA;
          addr_d    = daddr;
          store_d   = dstore;
          // A simultaneous read and write resolves to the write.
          wr_d      = dWEN;
          rd_d      = dREN & ~dWEN;
          is_data_d = 1'b1;
          cnt_d     = 8'd0;
        end else if (iREN) begin
          state_d   = INSTR;
          addr_d    = iaddr;
          store_d   = 32'd0;
          wr_d      = 1'b0;
          rd_d      = 1'b1;
          is_data_d = 1'b0;
          cnt_d     = 8'd0;
        end
      end
      DATA, INSTR: begin
        if (ramready) begin
          done    = 1'b1;
          cap_val = ramload;
        end else if (cnt_q == TIMEOUT) begin
          // Give up on the RAM: complete with a zero word and flag it.
          done    = 1'b1;
          cap_val = 32'd0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
        if (done) begin
          state_d = RESP;
          if (state_q == INSTR) begin
            iload_d = cap_val;
          end else if (rd_q) begin
            dload_d = cap_val;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    if (state_q == DATA) begin
      ramREN   = rd_q;
      ramWEN   = wr_q;
      ramaddr  = addr_q;
      ramstore = store_q;
    end else if (state_q == INSTR) begin
      ramREN  = 1'b1;
      ramaddr = addr_q;
    end
  end

  assign ihit  = (state_q == RESP) && !is_data_q;
  assign dhit  = (state_q == RESP) && is_data_q;
  assign iload = iload_q;
  assign dload = dload_q;
  assign err   = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, max cycles one RAM access may wait for ramready.
REQ-002 SHALL have ports: CLK  in  1  clock; all state updates on rising edge.
REQ-003 SHALL have: RST  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have: iREN  in  1  instruction fetch request; iaddr  in  32  fetch address.
REQ-005 SHALL have: dREN  in  1  data read request; dWEN  in  1  data write request.
REQ-006 SHALL have: daddr  in  32  data address; dstore  in  32  write data.
REQ-007 SHALL have: iload  out  32  fetched word; ihit  out  1  fetch-complete pulse.
REQ-008 SHALL have: dload  out  32  read word; dhit  out  1  data-complete pulse.
REQ-009 SHALL have: ramREN  out  1; ramWEN  out  1; ramaddr  out  32; ramstore  out  32  (RAM request side).
REQ-010 SHALL have: ramload  in  32  RAM read data; ramready  in  1  RAM access-complete strobe.
REQ-011 SHALL have: err  out  1  sticky timeout flag.

Function
REQ-012 SHALL implement FSM states IDLE, DATA, INSTR, RESP.
REQ-013 IDLE: requests sampled only here; dREN|dWEN -> DATA; else iREN -> INSTR; else stay IDLE.
REQ-014 Data priority: dREN|dWEN and iREN both high in IDLE -> DATA; iREN served on a later IDLE visit.
REQ-015 On IDLE exit SHALL latch address, dstore and op type; RAM outputs driven from latches only.
REQ-016 dREN and dWEN both high: SHALL perform a write; the read is dropped.
REQ-017 DATA: ramWEN=latched write, ramREN=latched read, ramaddr=latched daddr, ramstore=latched dstore.
REQ-018 INSTR: ramREN=1, ramWEN=0, ramaddr=latched iaddr, ramstore=0.
REQ-019 In IDLE and RESP, ramREN=ramWEN=0, ramaddr=ramstore=0.
REQ-020 DATA/INSTR with ramready=1: capture ramload into dload (data read) or iload (fetch), go RESP.
REQ-021 Data write completion SHALL leave dload unchanged.
REQ-022 RESP: exactly one cycle; dhit=1 if a data access completed, else ihit=1; then IDLE.
REQ-023 ihit and dhit SHALL never be high together and are 0 outside RESP.
REQ-024 iload/dload SHALL hold their captured value until the next capture of the same port.
REQ-025 Minimum latency: request in IDLE at edge N, ramready=1 at first DATA/INSTR cycle -> hit high in cycle N+2.
REQ-026 Requester deasserting mid-access: access SHALL complete; hit still pulses.
REQ-027 A request still high in the IDLE cycle after RESP SHALL start a new access.
REQ-028 SHALL keep an 8-bit wait counter: cleared on entry to DATA/INSTR, +1 per cycle without ramready.
REQ-029 Counter reaching TIMEOUT without ramready: SHALL set err=1, capture 32'h0 instead of ramload (reads), go RESP and pulse hit.
REQ-030 ramready coinciding with counter==TIMEOUT: SHALL count as normal completion, err unchanged.
REQ-031 err SHALL remain 1 until reset.
REQ-032 ramready while in IDLE or RESP SHALL be ignored.

Reset
REQ-033 RST=1 SHALL immediately force IDLE; counter=0; err=0; iload=dload=0; ihit=dhit=0; all ram outputs 0.
REQ-034 RST mid-access SHALL abandon the access with no hit; first post-reset IDLE resamples requests.

Verification
REQ-035 Read: dREN=1, daddr=0x40; ramready on 2nd DATA cycle with ramload=0x12345678 -> ramREN=1 ramaddr=0x40 two cycles, dhit one cycle, dload=0x12345678.
REQ-036 Contention: iREN=1 iaddr=0x0, dWEN=1 daddr=0x80 dstore=0xCAFE in same cycle -> write to 0x80 first with dhit, then fetch from 0x0 with ihit.
REQ-037 Both dREN and dWEN high, daddr=0x10 dstore=0xAA -> ramWEN=1, ramREN=0, dload unchanged.
REQ-038 Timeout: TIMEOUT=4, iREN=1, ramready held 0 -> after 4 wait cycles err=1, ihit pulse, iload=0; err stays 1 across later accesses.
REQ-039 Reset mid-access: RST pulsed in DATA -> ram outputs 0 at once, no dhit, err=0, FSM in IDLE.
REQ-040 Back-to-back: iREN held high, ramready=1 always -> ihit every 3rd cycle, never overlapping dhit.
